// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the sync FIFO drain block and its output buffer.
package sync_fifo_pkg;

  localparam int DATA_W_DEF    = 4;
  localparam int BUF_DEPTH_DEF = 3;
  localparam int DRAIN_CNT_W   = 16;

  // Modulo increment for pointers into buffers whose depth need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_drain_if.sv
// FIFO-side read handshake and downstream valid/ready bundle of the drain block.
interface sync_fifo_drain_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              fifo_rd_en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_data,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_data,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/drain_buf.sv
// Small circular output buffer: cleared storage, head/tail pointers with modulo wrap, occupancy count.
module drain_buf
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  localparam int PTR_W    = $clog2(BUF_DEPTH),
  localparam int CNT_W    = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  occ
);

  logic [DATA_W-1:0] mem_reg [BUF_DEPTH];
  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  occ_reg;
  logic              do_pop;

  assign do_pop    = pop && (occ_reg != '0);
  assign head_data = mem_reg[head_reg];
  assign occ       = occ_reg;

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_reg[i] <= '0;
    end else if (wr_en) begin
      mem_reg[tail_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      head_reg <= '0;
      tail_reg <= '0;
      occ_reg  <= '0;
    end else begin
      if (wr_en)  tail_reg <= PTR_W'(wrap_inc(32'(tail_reg), BUF_DEPTH));
      if (do_pop) head_reg <= PTR_W'(wrap_inc(32'(head_reg), BUF_DEPTH));
      // Capture and pop in the same cycle leave the count unchanged.
      case ({wr_en, do_pop})
        2'b10:   occ_reg <= occ_reg + CNT_W'(1);
        2'b01:   occ_reg <= occ_reg - CNT_W'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Plain synchronous FIFO with a registered read port: data_out is valid one cycle after rd_en.
module sync_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic              empty,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [AW-1:0]     wptr_reg, rptr_reg;
  logic [AW:0]       count_reg;
  logic              do_wr, do_rd;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem_reg[wptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      data_out  <= '0;
    end else begin
      if (do_wr) wptr_reg <= wptr_reg + AW'(1);
      if (do_rd) begin
        rptr_reg <= rptr_reg + AW'(1);
        data_out <= mem_reg[rptr_reg];
      end
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sync_fifo_drain.sv
// Drains a registered-read sync FIFO into a small output buffer with valid/ready output.
// Optional pop counter output drain_cnt when SYNC_FIFO_DRAIN_STATS_EN is defined.
module sync_fifo_drain
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_a,
  input  logic                   en,
  sync_fifo_drain_if.master      bus
`ifdef SYNC_FIFO_DRAIN_STATS_EN
  ,
  output logic [DRAIN_CNT_W-1:0] drain_cnt
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic              inflight_reg;
  logic [CNT_W-1:0]  occ;
  logic [CNT_W:0]    committed;
  logic              rd_en;
  logic              out_valid;
  logic              pop;
  logic [DATA_W-1:0] head_data;

  // Every issued read owns a buffer slot, so the buffer can never overflow.
  assign committed = {1'b0, occ} + {{CNT_W{1'b0}}, inflight_reg};
  assign rd_en     = !rst_a && en && !bus.fifo_empty && (committed < (CNT_W+1)'(BUF_DEPTH));
  assign out_valid = (occ != '0);
  assign pop       = out_valid && bus.out_ready;

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = head_data;

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) inflight_reg <= 1'b0;
    else       inflight_reg <= rd_en;
  end

  drain_buf #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_a     (rst_a),
    .wr_en     (inflight_reg),
    .wr_data   (bus.fifo_data),
    .pop       (pop),
    .head_data (head_data),
    .occ       (occ)
  );

`ifdef SYNC_FIFO_DRAIN_STATS_EN
  logic [DRAIN_CNT_W-1:0] drain_cnt_reg;

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a)    drain_cnt_reg <= '0;
    else if (pop) drain_cnt_reg <= drain_cnt_reg + DRAIN_CNT_W'(1);
  end

  assign drain_cnt = drain_cnt_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_drain.sv
// Scoreboard bench: sync_fifo (depth 8) feeding sync_fifo_drain; a negedge monitor checks order.
module tb_sync_fifo_drain;

  localparam int DW = 4;
  localparam int BD = 3;

  logic          clk = 1'b0;
  logic          rst_a = 1'b1;
  logic          en = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int held = 0;
  int max_held = 0;
  int exp_q[$];
  int pop_cyc[$];
  int rd_cyc[$];

`ifdef SYNC_FIFO_DRAIN_STATS_EN
  logic [15:0] drain_cnt;
`endif

  sync_fifo_drain_if #(.DATA_W(DW)) bus ();

  sync_fifo #(.DATA_W(DW), .DEPTH(8)) u_fifo (
    .clk      (clk),
    .rst_a    (rst_a),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .rd_en    (bus.fifo_rd_en),
    .empty    (bus.fifo_empty),
    .data_out (bus.fifo_data)
  );

  sync_fifo_drain #(.DATA_W(DW), .BUF_DEPTH(BD)) dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .en        (en),
    .bus       (bus)
`ifdef SYNC_FIFO_DRAIN_STATS_EN
    ,
    .drain_cnt (drain_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: every accepted output word must be the oldest word written into the FIFO.
  always @(negedge clk) begin : monitor
    int e;
    if (rst_a) begin
      held = 0;
    end else begin
      if (bus.fifo_rd_en) rd_cyc.push_back(cyc);
      held = held + (bus.fifo_rd_en ? 1 : 0) - ((bus.out_valid && bus.out_ready) ? 1 : 0);
      if (held > max_held) max_held = held;
      if (bus.out_valid && bus.out_ready) begin
        pop_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected actual=%0h required=<no word pending>", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if (int'(bus.out_data) != e) begin
            failures++;
            $display("FAIL pop_order actual=%0h required=%0h", bus.out_data, e);
          end else begin
            $display("pop word=%0h cycle=%0d", bus.out_data, cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input int v);
    wr_en = 1'b1;
    wr_data = DW'(v);
    if (!full) exp_q.push_back(v & ((1 << DW) - 1));
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_done_pending", exp_q.size(), 0);
    exp_q.delete();
    tick(3);
  endtask

  initial begin
    en = 1'b1;
    bus.out_ready = 1'b1;
    #2;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_fifo_rd_en", int'(bus.fifo_rd_en), 0);
    tick(3);
    rst_a = 1'b0;
    tick(2);

    // Three words stream straight through with two-cycle latency.
    rd_cyc.delete(); pop_cyc.delete();
    put(1); put(2); put(3);
    wait_drain(30);
    check("s1_pops", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3 && rd_cyc.size() > 0) begin
      check("s1_latency", pop_cyc[0] - rd_cyc[0], 2);
      check("s1_consecutive", pop_cyc[2] - pop_cyc[0], 2);
    end

    // Back-pressure: only BD reads may be outstanding.
    bus.out_ready = 1'b0;
    rd_cyc.delete();
    for (int i = 0; i < 8; i++) put(i);
    tick(10);
    check("s2_reads_issued", rd_cyc.size(), BD);
    check("s2_rd_en_idle", int'(bus.fifo_rd_en), 0);
    check("s2_out_valid", int'(bus.out_valid), 1);
    pop_cyc.delete();
    bus.out_ready = 1'b1;
    wait_drain(40);
    check("s2_pops", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) check("s2_no_gap", pop_cyc[7] - pop_cyc[0], 7);

    // Ready toggling every cycle across pointer wrap.
    pop_cyc.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) put(8 + i);
      end
      begin
        repeat (40) begin
          bus.out_ready = ~bus.out_ready;
          tick();
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain(40);
    check("s3_pops", pop_cyc.size(), 8);

    // Drop en with word 5 in flight.
    en = 1'b0;
    put(5); put(6);
    tick(3);
    check("s4_rd_en_when_disabled", int'(bus.fifo_rd_en), 0);
    rd_cyc.delete();
    en = 1'b1;
    tick();
    en = 1'b0;
    tick(10);
    check("s4_reads_while_off", rd_cyc.size(), 1);
    check("s4_words_left", exp_q.size(), 1);
    en = 1'b1;
    wait_drain(30);

    // Asynchronous reset with two buffered words.
    bus.out_ready = 1'b0;
    put(7); put(8);
    tick(5);
    check("s5_valid_before_rst", int'(bus.out_valid), 1);
    #2;
    rst_a = 1'b1;
    #1;
    check("s5_valid_async", int'(bus.out_valid), 0);
    check("s5_rd_en_async", int'(bus.fifo_rd_en), 0);
    check("s5_data_async", int'(bus.out_data), 0);
    exp_q.delete();
    tick(2);
    rst_a = 1'b0;
    pop_cyc.delete();
    bus.out_ready = 1'b1;
    put(10); put(11);
    wait_drain(30);
    check("s5_pops_after_rst", pop_cyc.size(), 2);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      bus.out_ready = 1'($urandom_range(0, 1));
      if (!full && $urandom_range(0, 1) == 1) begin
        wr_en = 1'b1;
        wr_data = DW'($urandom);
        exp_q.push_back(int'(wr_data));
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    en = 1'b1;
    bus.out_ready = 1'b1;
    wait_drain(100);
    check("held_within_depth", (max_held <= BD) ? 1 : 0, 1);

`ifdef SYNC_FIFO_DRAIN_STATS_EN
    rst_a = 1'b1;
    tick(2);
    rst_a = 1'b0;
    for (int i = 0; i < 10; i++) put(i);
    wait_drain(40);
    check("stats_drain_cnt", int'(drain_cnt), 10);
    rst_a = 1'b1;
    #1;
    check("stats_drain_cnt_rst", int'(drain_cnt), 0);
    tick(2);
    rst_a = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_drain.md
SYNC_FIFO_DRAIN -- requirements
Module: sync_fifo_drain

Interface
REQ-001 Parameter DATA_W, default 4: FIFO and output data width in bits.
REQ-002 Parameter BUF_DEPTH, default 3: output buffer entries, legal range 3..8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_a  input  1  reset; asynchronous, active-high.
REQ-005 en  input  1  drain enable; when low, no new FIFO reads are issued.
REQ-006 fifo_empty  input  1  empty flag from the drained sync FIFO.
REQ-007 fifo_data  input  DATA_W  FIFO data_out, valid one cycle after rd_en sampled high while not empty.
REQ-008 fifo_rd_en  output  1  read request to the FIFO.
REQ-009 out_data  output  DATA_W  head word of the output buffer.
REQ-010 out_valid  output  1  out_data holds a word.
REQ-011 out_ready  input  1  downstream accepts the word when out_valid && out_ready.

Function
REQ-012 fifo_rd_en SHALL be en && !fifo_empty && (occ + inflight < BUF_DEPTH), where occ is the buffer count and inflight is a 1-bit register equal to the previous cycle's fifo_rd_en.
REQ-013 fifo_rd_en SHALL have no combinational dependence on out_ready.
REQ-014 When inflight is 1, fifo_data SHALL be written into the buffer at the tail pointer at that clock edge.
REQ-015 out_valid SHALL be (occ != 0), driven from registers only.
REQ-016 out_data SHALL be the entry at the head pointer, driven from registers only.
REQ-017 A pop occurs when out_valid && out_ready; the head pointer SHALL then advance.
REQ-018 Head and tail pointers SHALL wrap from BUF_DEPTH-1 to 0; BUF_DEPTH need not be a power of two.
REQ-019 On a simultaneous capture and pop, occ SHALL be unchanged and both pointers SHALL advance.
REQ-020 Latency SHALL be 2 cycles: fifo_rd_en high in cycle N gives out_valid high in cycle N+2 if the buffer was empty.
REQ-021 Throughput SHALL be one word per cycle while the FIFO is non-empty, en=1 and out_ready=1.
REQ-022 The buffer SHALL never overflow, because the occ + inflight bound in REQ-012 guarantees a free entry for every in-flight read.
REQ-023 Deasserting en SHALL still capture the in-flight word and SHALL leave buffered words available for output.
REQ-024 Words SHALL leave in exactly FIFO order; none SHALL be dropped or duplicated.

Reset
REQ-025 While rst_a is high, and immediately on its assertion, the block SHALL set occ=0, inflight=0, head=0 and tail=0, drive fifo_rd_en=0 and out_valid=0, and drive out_data=0 with buffer contents cleared.
REQ-026 Reset asserted mid-operation SHALL discard all buffered and in-flight words; the first read after release SHALL be issued no earlier than the first rising edge after rst_a falls.

Configuration
REQ-027 With SYNC_FIFO_DRAIN_STATS_EN defined, the block SHALL add output drain_cnt (16 bits); it resets to 0, increments on every pop and wraps 0xFFFF->0.
REQ-028 Without SYNC_FIFO_DRAIN_STATS_EN, the drain_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 A shared package sync_fifo_pkg SHALL hold the DATA_W default (4), the BUF_DEPTH default (3) and the drain_cnt width (16).
REQ-030 The buffer SHALL be one sub-module, drain_buf (storage, head/tail wrap, occ counter); sync_fifo_drain holds the read-request and inflight logic.

Verification
REQ-031 Bench SHALL instantiate sync_fifo (depth 8, DATA_W 4) driving this block and cover the scenarios below.
REQ-032 Write 1,2,3 with en=1 and out_ready=1 -> out_data 1,2,3 on three consecutive valid cycles; first out_valid 2 cycles after the first fifo_rd_en.
REQ-033 Fill with 0..7 and hold out_ready=0 -> exactly 3 reads issued, occ=3, fifo_rd_en stays 0; release ready -> 0..7 in order with no gaps.
REQ-034 Stream 8 words with out_ready toggling every cycle -> all 8 delivered in order; pointers wrap at 2->0 without loss.
REQ-035 Drop en while a read is in flight (word 5) -> 5 still appears on out_data; no further fifo_rd_en until en=1.
REQ-036 Assert rst_a mid-stream with 2 buffered words -> out_valid=0 in the same cycle; after release, new writes 0xA,0xB appear as the first outputs.
REQ-037 With SYNC_FIFO_DRAIN_STATS_EN defined, 10 pops -> drain_cnt=10; reset -> drain_cnt=0.
